cell_config_loader: RTL



---
 rtl/cell_config_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cell_config_loader.sv
// cell_config_loader
// Serial configuration writer for a row of shifter/XOR cells. Bits arrive
// LSB first over a valid/ready handshake. They are assembled in a shadow
// shift register. A complete stream is then committed to the active
// configuration bus in a single cycle, so the cells never see a partial load.
//
// Per-cell field layout at base 7*i:
//   [7i]       byPass
//   [7i+2:7i+1] sel0
//   [7i+4:7i+3] sel1
//   [7i+6:7i+5] selOp
module cell_config_loader #(
    parameter int NUM_CELLS = 8,
    parameter int CFG_BITS  = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfgStart,
    input  logic                            cfgBit,
    input  logic                            cfgValid,
    output logic                            cfgReady,
    output logic                            busy,
    output logic                            done,
    output logic                            cfgSerialOut,
    output logic [NUM_CELLS*CFG_BITS-1:0]   cfgOut
);

    localparam int TOTAL = NUM_CELLS * CFG_BITS;
    localparam int CNT_W = $clog2(TOTAL + 1);

    // Safe passthrough: every cell bypassed, all selects zero.
    localparam logic [CFG_BITS-1:0] CELL_PASS = {{(CFG_BITS-1){1'b0}}, 1'b1};
    localparam logic [TOTAL-1:0]    CFG_PASS  = {NUM_CELLS{CELL_PASS}};

    // Index of the last bit of a stream; accepting it completes the load.
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TOTAL - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [TOTAL-1:0] shadow_q, shadow_d;
    logic [TOTAL-1:0] cfg_out_q, cfg_out_d;
    logic             serial_q, serial_d;
    logic             done_q,   done_d;
    logic             xfer;

    // The handshake outputs depend only on registered state. This keeps
    // cfgValid from reaching cfgReady through any combinational path.
    assign cfgReady     = (state_q == SHIFT);
    assign busy         = (state_q == SHIFT) || (state_q == COMMIT);
    assign done         = done_q;
    assign cfgSerialOut = serial_q;
    assign cfgOut       = cfg_out_q;

    // A bit is accepted only when no restart is requested in the same cycle.
    assign xfer = cfgValid && cfgReady && !cfgStart;

    // Next-state logic for the IDLE -> SHIFT -> COMMIT sequence and its datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        cfg_out_d = cfg_out_q;
        serial_d  = serial_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // cfgValid is deliberately ignored here.
                if (cfgStart) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                if (cfgStart) begin
                    // Restart. The old shadow bits are not cleared. A full new
                    // stream shifts every one of them out before the commit.
                    cnt_d = '0;
                end else if (xfer) begin
                    shadow_d = {cfgBit, shadow_q[TOTAL-1:1]};
                    serial_d = shadow_q[0];
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = COMMIT;
                    end
                end
            end

            COMMIT: begin
                // A single-cycle atomic update. cfgStart has no effect here.
                cfg_out_d = shadow_q;
                state_d   = IDLE;
                done_d    = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. An asynchronous reset restores the passthrough bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            cfg_out_q <= CFG_PASS;
            serial_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            cfg_out_q <= cfg_out_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
        end
    end

endmodule
